regfile_sb: RTL and testbench



---
 rtl/regfile_sb.sv | 92 +++++++++
 tb/tb_regfile_sb.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// General-purpose register file with configurable read ports, optional write-to-read bypass,
// and a per-register pending scoreboard that keeps a running count of outstanding producers.
module regfile_sb #(
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter int NREAD       = 2,
  parameter int BYPASS      = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NREAD*RFIDX_WIDTH-1:0] ra,
  output logic [NREAD*XLEN-1:0]        rd,
  output logic [NREAD-1:0]             rd_busy,
  input  logic                         we,
  input  logic [RFIDX_WIDTH-1:0]       wa,
  input  logic [XLEN-1:0]              wd,
  input  logic                         iss_valid,
  input  logic [RFIDX_WIDTH-1:0]       iss_rd,
  output logic [RFIDX_WIDTH:0]         pend_cnt,
  input  logic [RFIDX_WIDTH-1:0]       dbg_ra,
  output logic [XLEN-1:0]              dbg_rd
);
  localparam int NREGS = 2**RFIDX_WIDTH;
  localparam int CW    = RFIDX_WIDTH + 1;

  logic [XLEN-1:0]  rf_q [NREGS];
  logic [NREGS-1:0] pend_q, pend_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cnt_inc, cnt_dec;

  // Entry 0 is reset to zero and never written, so it reads as the hardwired x0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) rf_q[r] <= '0;
    end else if (we && (wa != '0)) begin
      rf_q[wa] <= wd;
    end
  end

  // A newly issued producer overrides a same-cycle writeback of the older one.
  always_comb begin
    pend_d = pend_q;
    pend_d[0] = 1'b0;
    for (int r = 1; r < NREGS; r++) begin
      pend_d[r] = (iss_valid && (iss_rd == RFIDX_WIDTH'(r))) ||
                  (pend_q[r] && !(we && (wa == RFIDX_WIDTH'(r))));
    end
  end

  // The count moves only on real 0->1 / 1->0 transitions of the pending bits.
  always_comb begin
    cnt_inc = iss_valid && (iss_rd != '0) && !pend_q[iss_rd];
    cnt_dec = we && (wa != '0) && pend_q[wa] && !(iss_valid && (iss_rd == wa));
    cnt_d   = cnt_q + CW'(cnt_inc) - CW'(cnt_dec);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_cnt = cnt_q;
  assign dbg_rd   = rf_q[dbg_ra];

  for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
    logic [RFIDX_WIDTH-1:0] addr;
    logic [XLEN-1:0]        data;
    logic                   busy;

    assign addr = ra[gi*RFIDX_WIDTH +: RFIDX_WIDTH];

    always_comb begin
      data = rf_q[addr];
      busy = pend_q[addr];
      if (addr == '0) begin
        data = '0;
        busy = 1'b0;
      end else if ((BYPASS != 0) && we && (wa == addr)) begin
        data = wd;
        busy = 1'b0;
      end
    end

    assign rd[gi*XLEN +: XLEN] = data;
    assign rd_busy[gi]         = busy;
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a bypassing and a non-bypassing instance share stimulus and are
// compared against an array-based reference model of the register file and scoreboard.
module tb_regfile_sb;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ra0, ra1;
  logic [9:0]  ra_bus;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  dbg_ra;

  logic [63:0] rd_b1, rd_b0;
  logic [1:0]  busy_b1, busy_b0;
  logic [5:0]  cnt_b1, cnt_b0;
  logic [31:0] dbg_b1, dbg_b0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_rf [32];
  bit          m_pend [32];

  assign ra_bus = {ra1, ra0};

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(32), .RFIDX_WIDTH(5), .NREAD(2), .BYPASS(1)) u_byp (
    .clk(clk), .reset(reset), .ra(ra_bus), .rd(rd_b1), .rd_busy(busy_b1),
    .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .pend_cnt(cnt_b1), .dbg_ra(dbg_ra), .dbg_rd(dbg_b1)
  );

  regfile_sb #(.XLEN(32), .RFIDX_WIDTH(5), .NREAD(2), .BYPASS(0)) u_nobyp (
    .clk(clk), .reset(reset), .ra(ra_bus), .rd(rd_b0), .rd_busy(busy_b0),
    .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .pend_cnt(cnt_b0), .dbg_ra(dbg_ra), .dbg_rd(dbg_b0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int model_count();
    int c = 0;
    for (int r = 0; r < 32; r++) c += int'(m_pend[r]);
    return c;
  endfunction

  // Compare every output of both instances with the model for the inputs now applied.
  task automatic check_all(input string tag);
    logic [4:0]  a;
    logic [31:0] exp_d;
    logic        exp_b;
    #2;
    for (int b = 0; b < 2; b++) begin
      for (int p = 0; p < 2; p++) begin
        a = (p == 0) ? ra0 : ra1;
        if (a == 5'd0) begin
          exp_d = 32'd0;
          exp_b = 1'b0;
        end else if (b == 1 && we && wa == a) begin
          exp_d = wd;
          exp_b = 1'b0;
        end else begin
          exp_d = m_rf[a];
          exp_b = m_pend[a];
        end
        chk($sformatf("%s.byp%0d.rd%0d", tag, b, p),
            (b == 1) ? rd_b1[p*32 +: 32] : rd_b0[p*32 +: 32], exp_d);
        chk($sformatf("%s.byp%0d.busy%0d", tag, b, p),
            {31'd0, (b == 1) ? busy_b1[p] : busy_b0[p]}, {31'd0, exp_b});
      end
      chk($sformatf("%s.byp%0d.pend_cnt", tag, b),
          {26'd0, (b == 1) ? cnt_b1 : cnt_b0}, model_count());
      chk($sformatf("%s.byp%0d.dbg_rd", tag, b),
          (b == 1) ? dbg_b1 : dbg_b0, (dbg_ra == 5'd0) ? 32'd0 : m_rf[dbg_ra]);
    end
  endtask

  // Advance one clock and apply the architectural rules to the model.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int r = 0; r < 32; r++) begin
        m_rf[r]   = 32'd0;
        m_pend[r] = 1'b0;
      end
    end else begin
      if (we && wa != 5'd0) begin
        m_rf[wa]   = wd;
        m_pend[wa] = 1'b0;
      end
      if (iss_valid && iss_rd != 5'd0) m_pend[iss_rd] = 1'b1;
    end
    #1;
  endtask

  task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic iv, input logic [4:0] ir);
    we = w; wa = a; wd = d; iss_valid = iv; iss_rd = ir;
  endtask

  task automatic set_read(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] da);
    ra0 = a0; ra1 = a1; dbg_ra = da;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b1, 5'(($urandom_range(1, 31))), $urandom, 1'b1, 5'(($urandom_range(1, 31))));
    set_read(5'd0, 5'd0, 5'd0);
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

    for (int a = 0; a < 32; a++) begin
      set_read(5'(a), 5'(31 - a), 5'(a));
      check_all($sformatf("reset_read%0d", a));
    end

    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
    set_read(5'd5, 5'd5, 5'd5);
    check_all("wr5_same_cycle");
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    check_all("wr5_next_cycle");

    drive(1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0);
    set_read(5'd0, 5'd5, 5'd0);
    check_all("x0_write");
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    check_all("x0_after");

    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    set_read(5'd7, 5'd9, 5'd7);
    check_all("pend_7_9");
    drive(1'b1, 5'd7, 32'h000000A5, 1'b1, 5'd7);
    check_all("set_clr_7");
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    check_all("after_set_clr_7");
    drive(1'b1, 5'd7, 32'h0000005A, 1'b0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    check_all("clr_7");

    drive(1'b1, 5'd9, 32'h00000099, 1'b1, 5'd3);
    set_read(5'd3, 5'd9, 5'd9);
    check_all("set3_clr9");
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    check_all("after_set3_clr9");

    for (int r = 1; r < 32; r++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(r));
      tick();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    set_read(5'd31, 5'd1, 5'd9);
    check_all("all_pending");
    reset = 1'b1;
    drive(1'b1, 5'd4, 32'hCAFEF00D, 1'b1, 5'd4);
    tick();
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    set_read(5'd4, 5'd31, 5'd4);
    check_all("mid_reset");

    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 2) == 0) set_read(wa, 5'($urandom_range(0, 31)), wa);
      else set_read(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if (!reset) check_all($sformatf("rand%0d", n));
      tick();
    end
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    check_all("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
